step_size_gen: RTL and testbench
================================

// Module: step_size_gen
// PURPOSE
//   Parametrised NCO phase-step generator: MIDI note (0..127) plus an upward fine-tune
//   fraction in, phase-accumulator step out. Sits between the voice allocator and the
//   per-voice NCO phase accumulator.
//   Replaces the 128-entry per-note table with three parts:
//   - a 13-entry one-octave mantissa table;
//   - an iterative octave/semitone split;
//   - linear fine-tune interpolation, multiply and rounded shift.
//   Valid/ready handshake on both sides; a tag is carried through unchanged.
// PARAMETERS
//   OUT_W    16     width of step output
//   REF_STEP 17146  step for note 120 (top-octave C), fine=0; OUT_W bits
//   FINE_W   8      fine-tune width; fraction of one semitone = fine/2^FINE_W
//   TAG_W    4      width of voice tag carried input->output
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   ce         in   1       clock enable; ce=0 freezes all state (handshake outputs hold)
//   in_valid   in   1       request valid
//   in_ready   out  1       block can accept (high only in IDLE)
//   in_note    in   7       MIDI note number
//   in_fine    in   FINE_W  upward fine tune
//   in_tag     in   TAG_W   voice tag
//   out_valid  out  1       step/tag valid, held until consumed
//   out_ready  in   1       consumer accepts
//   out_step   out  OUT_W   computed phase step
//   out_tag    out  TAG_W   tag of the request
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_step=0, out_tag=0.
//   Mantissa table M[k] = round(2^(k/12)*32768), 17 bits, k=0..12:
//     32768 34716 36781 38968 41285 43740 46341 49097 52016 55109 58386 61858 65536
//   Accept: rising edge with ce & in_valid & in_ready. Latch note/fine/tag; rem=note, oct=0; go to DIV.
//   DIV: per ce cycle, if rem>=12 then rem-=12, oct+=1; else go to INTERP. Takes oct+1 cycles.
//   INTERP: Meff = M[rem] + (((M[rem+1]-M[rem]) * fine) >> FINE_W); 17 bits, truncating.
//   MUL: prod = REF_STEP * Meff, exact, OUT_W+17 bits.
//   ROUND: s = 15 + (10-oct); res = (prod + 2^(s-1)) >> s.
//     If res > 2^OUT_W-1, res is saturated to all-ones.
//     Register out_step and out_tag; go to DONE.
//   DONE: out_valid=1, out_step and out_tag stable. Handshake completes on ce & out_ready;
//     on completion out_valid drops next cycle and state returns to IDLE.
//     in_ready rises in the same cycle; no overlap of requests.
//   Latency: out_valid high oct+4 ce-cycles after the accept edge, where oct=floor(note/12).
//     Range 4 (note 0..11) to 14 (note 120..127).
//   Idle throughput: one request in flight. in_valid during busy is ignored;
//     the source holds it.
//   ce=0 in any state: no state, counter or output change; out_ready is ignored.
//   Reset asserted mid-DIV/MUL/DONE aborts the request; no output is produced for it.
//   Boundaries:
//     - rem=11 uses M[12]=65536 as upper interpolation point;
//     - fine=0 gives exact M[rem];
//     - note 127 maximum oct=10 (s=15).
// CONFIGURATION
//   STEP_GEN_FAST_DIV_EN defined:
//     - DIV is one cycle for every note;
//     - octave and remainder come from a combinational divide-by-12 of the 7-bit note;
//     - latency is fixed at 4 cycles.
//   Undefined: iterative subtraction as above; latency oct+4. Results are bit-identical
//     in both builds.
// TESTING
//   note=120 fine=0 -> out_step=17146, latency 14.
//   note=69 fine=0 -> out_step=901; note=60 -> 536; note=0 -> 17, latency 4.
//   note=120 fine=128 (FINE_W=8) -> Meff=33742, out_step=17656.
//   note=127 fine=0 tag=5 -> out_step=25690, out_tag=5.
//     With out_ready=0 for 10 cycles, out_valid and step stay held; in_ready stays 0.
//   ce toggled 0/1 every cycle on note=60 -> latency in ce-cycles still 9, same result.
//     rst_n pulsed low mid-DIV -> out_valid=0, in_ready=1 immediately; next request correct.
//   Sweep notes 0..127 at fine 0/255 vs model, both STEP_GEN_FAST_DIV_EN builds.
//     Bit-exact results; latency 4 (fast) or oct+4.

Source files
------------

// File: rtl/step_size_gen.sv
// step_size_gen: MIDI note + upward fine tune -> NCO phase-accumulator step.
// The octave is split off the note, a one-octave mantissa is interpolated by the
// fine fraction, then scaled by REF_STEP and shifted down per octave with rounding.
// Build option: STEP_GEN_FAST_DIV_EN selects a single-cycle divide-by-12 instead of
// iterative subtraction (results are identical; latency becomes a fixed 4 cycles).
module step_size_gen #(
   parameter int unsigned OUT_W    = 16,
   parameter int unsigned REF_STEP = 17146,
   parameter int unsigned FINE_W   = 8,
   parameter int unsigned TAG_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_note,
   input  logic [FINE_W-1:0] in_fine,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_step,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int unsigned M_W    = 17;
   localparam int unsigned IP_W   = M_W + FINE_W;
   localparam int unsigned PROD_W = OUT_W + M_W;
   localparam int unsigned SUM_W  = PROD_W + 1;
   localparam int unsigned NOTE_W = 7;
   localparam int unsigned OCT_W  = 4;
   localparam int unsigned SH_W   = 5;
   // shift for octave 0 is 15 + 10; each octave up removes one bit of shift
   localparam logic [SH_W-1:0] S_BASE = SH_W'(25);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIV,
      S_INTERP,
      S_MUL,
      S_ROUND,
      S_DONE
   } state_t;

   state_t              state;
   logic [NOTE_W-1:0]   rem_q;
   logic [OCT_W-1:0]    oct_q;
   logic [FINE_W-1:0]   fine_q;
   logic [TAG_W-1:0]    tag_q;
   logic [M_W-1:0]      meff_q;
   logic [PROD_W-1:0]   prod_q;

   logic [M_W-1:0]      m_lo;
   logic [M_W-1:0]      m_hi;
   logic [M_W-1:0]      m_diff;
   logic [IP_W-1:0]     interp_prod;
   logic [M_W-1:0]      meff_c;
   logic [PROD_W-1:0]   prod_c;
   logic [SH_W-1:0]     shift_c;
   logic [SUM_W-1:0]    sum_c;
   logic [SUM_W-1:0]    res_c;
   logic [OUT_W-1:0]    step_c;

   // One-octave mantissa table: round(2^(k/12) * 32768), k = 0..12
   function automatic logic [M_W-1:0] mant(input logic [3:0] k);
      case (k)
         4'd0:    mant = 17'd32768;
         4'd1:    mant = 17'd34716;
         4'd2:    mant = 17'd36781;
         4'd3:    mant = 17'd38968;
         4'd4:    mant = 17'd41285;
         4'd5:    mant = 17'd43740;
         4'd6:    mant = 17'd46341;
         4'd7:    mant = 17'd49097;
         4'd8:    mant = 17'd52016;
         4'd9:    mant = 17'd55109;
         4'd10:   mant = 17'd58386;
         4'd11:   mant = 17'd61858;
         default: mant = 17'd65536;
      endcase
   endfunction

   // Linear interpolation between adjacent semitone mantissas (rem=11 uses M[12])
   always_comb begin
      m_lo        = mant(rem_q[3:0]);
      m_hi        = mant(rem_q[3:0] + 4'd1);
      m_diff      = m_hi - m_lo;
      interp_prod = IP_W'(m_diff) * IP_W'(fine_q);
      meff_c      = m_lo + M_W'(interp_prod >> FINE_W);
   end

   // Exact scale of the interpolated mantissa by the reference step
   always_comb begin
      prod_c = PROD_W'(REF_STEP) * PROD_W'(meff_q);
   end

   // Round-half-up shift by octave, saturating to the output width
   always_comb begin
      shift_c = S_BASE - SH_W'(oct_q);
      sum_c   = SUM_W'(prod_q) + (SUM_W'(1) << (shift_c - SH_W'(1)));
      res_c   = sum_c >> shift_c;
      if (|res_c[SUM_W-1:OUT_W]) begin
         step_c = '1;
      end else begin
         step_c = res_c[OUT_W-1:0];
      end
   end

`ifdef STEP_GEN_FAST_DIV_EN
   logic [OCT_W-1:0]  fast_oct;
   logic [NOTE_W-1:0] fast_rem;

   // Single-cycle divide of the latched note by 12
   always_comb begin
      fast_oct = OCT_W'(rem_q / NOTE_W'(12));
      fast_rem = rem_q - (NOTE_W'(fast_oct) * NOTE_W'(12));
   end
`endif

   // Request sequencing, datapath registers and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_step  <= '0;
         out_tag   <= '0;
         rem_q     <= '0;
         oct_q     <= '0;
         fine_q    <= '0;
         tag_q     <= '0;
         meff_q    <= '0;
         prod_q    <= '0;
      end else if (ce) begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  rem_q    <= in_note;
                  oct_q    <= '0;
                  fine_q   <= in_fine;
                  tag_q    <= in_tag;
                  in_ready <= 1'b0;
                  state    <= S_DIV;
               end
            end
            S_DIV: begin
`ifdef STEP_GEN_FAST_DIV_EN
               rem_q <= fast_rem;
               oct_q <= fast_oct;
               state <= S_INTERP;
`else
               if (rem_q >= NOTE_W'(12)) begin
                  rem_q <= rem_q - NOTE_W'(12);
                  oct_q <= oct_q + OCT_W'(1);
               end else begin
                  state <= S_INTERP;
               end
`endif
            end
            S_INTERP: begin
               meff_q <= meff_c;
               state  <= S_MUL;
            end
            S_MUL: begin
               prod_q <= prod_c;
               state  <= S_ROUND;
            end
            S_ROUND: begin
               out_step  <= step_c;
               out_tag   <= tag_q;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_step_size_gen.sv
// tb_step_size_gen: directed requests against an arithmetic model of the step formula.
module tb_step_size_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ce;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_note;
   logic [7:0] in_fine;
   logic [3:0] in_tag;
   logic       out_valid;
   logic       out_ready;
   logic [15:0] out_step;
   logic [3:0] out_tag;

   int  errors = 0;
   int  checks = 0;
   bit  ce_mode = 1'b0;
   int  exp_step = 0;
   int  exp_tag = 0;

   step_size_gen dut (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_note(in_note), .in_fine(in_fine), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_step(out_step), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Step from the formula: 2^(note/12) scaled reference, fine as a fraction of a semitone
   function automatic int model_step(input int note, input int fine);
      longint mt [0:12];
      longint meff, prod, res;
      int oct, rem, s;
      mt = '{32768, 34716, 36781, 38968, 41285, 43740, 46341,
             49097, 52016, 55109, 58386, 61858, 65536};
      oct  = note / 12;
      rem  = note % 12;
      meff = mt[rem] + (((mt[rem+1] - mt[rem]) * fine) / 256);
      prod = 64'd17146 * meff;
      s    = 15 + (10 - oct);
      res  = (prod + (64'd1 << (s - 1))) >> s;
      if (res > 65535) res = 65535;
      return int'(res);
   endfunction

   function automatic int model_lat(input int note);
`ifdef STEP_GEN_FAST_DIV_EN
      return 4 + (note - note);
`else
      return note / 12 + 4;
`endif
   endfunction

   // Output must match the in-flight request on every cycle it is presented
   always @(negedge clk) begin
      if (out_valid) begin
         check("held_step", out_step, exp_step);
         check("held_tag", out_tag, exp_tag);
         check("busy_in_ready", in_ready, 0);
      end
   end

   task automatic tick();
      @(negedge clk);
      if (ce_mode) ce = ~ce;
      else ce = 1'b1;
   endtask

   task automatic do_req(input int note, input int fine, input int tag, input int hold,
                         input int lit_step, input int lit_slow_lat);
      int guard;
      int lat;
      bit prev_ce;
      exp_step  = model_step(note, fine);
      exp_tag   = tag;
      in_note   = 7'(note);
      in_fine   = 8'(fine);
      in_tag    = 4'(tag);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      guard = 0;
      while (!(ce && in_ready)) begin
         tick();
         guard++;
         if (guard > 200) begin
            check("accept_timeout", guard, 0);
            in_valid = 1'b0;
            return;
         end
      end
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid) begin
         prev_ce = ce;
         tick();
         if (prev_ce) lat++;
         if (lat > 40) begin
            check("valid_timeout", lat, model_lat(note));
            return;
         end
      end
      check("latency", lat, model_lat(note));
      check("step", out_step, exp_step);
      check("tag", out_tag, tag);
      if (lit_step >= 0) check("lit_step", out_step, lit_step);
      if (lit_slow_lat >= 0) begin
`ifdef STEP_GEN_FAST_DIV_EN
         check("lit_latency", lat, 4 + (lit_slow_lat - lit_slow_lat));
`else
         check("lit_latency", lat, lit_slow_lat);
`endif
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      guard = 0;
      while (out_valid) begin
         tick();
         guard++;
         if (guard > 10) begin
            check("consume_timeout", guard, 0);
            break;
         end
      end
      out_ready = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; in_note = '0; in_fine = '0;
      in_tag = '0; out_ready = 1'b0;
      tick(); tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_step", out_step, 0);
      check("rst_out_tag", out_tag, 0);
      rst_n = 1'b1;
      tick();

      do_req(120, 0, 1, 0, 17146, 14);
      do_req(69, 0, 2, 0, 901, 9);
      do_req(60, 0, 3, 0, 536, 9);
      do_req(0, 0, 4, 0, 17, 4);
      do_req(120, 128, 6, 0, 17656, 14);
      do_req(127, 0, 5, 10, 25690, 14);
      do_req(11, 255, 7, 2, -1, 4);

      // ce toggling every cycle: latency counted in enabled cycles is unchanged
      ce_mode = 1'b1;
      do_req(60, 0, 3, 3, 536, 9);
      ce_mode = 1'b0;
      tick();

      // Reset in the middle of the octave split aborts the request
      in_note = 7'd60; in_fine = '0; in_tag = 4'd9; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid || !in_ready) cnt++;
      end
      check("abort_no_output", cnt, 0);
      do_req(69, 0, 10, 0, 901, 9);

      for (int n = 0; n < 128; n++) begin
         do_req(n, 0, n % 16, 0, -1, -1);
         do_req(n, 255, (n + 3) % 16, 0, -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
